uart_txr: RTL

Byte-wide UART transmitter: the upstream partner of `uart_rxr` that drives the serial line it samples. It accepts bytes over a valid/ready handshake into a small FIFO and serialises each as an 8N1 frame, or 8E1 when parity is enabled. It shares `uart_rxr`'s bit-period parameter, so the two can be looped back directly.

---
 rtl/uart_txr.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/uart_txr.sv
// rtl/uart_txr.sv - byte-wide UART transmitter with input FIFO; 8N1 by default,
// 8E1 when UART_TX_PARITY_EN is defined.
module uart_txr #(
  parameter int CLKS_PER_BIT = 10,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_data_valid,
  input  logic [7:0] i_data_byte,
  output logic       o_data_ready,
  output logic       o_tx_data_line,
  output logic       o_tx_busy,
  output logic       o_tx_done
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(CLKS_PER_BIT - 1);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

  state_t        r_state;
  state_t        w_state_next;
  logic [CW-1:0] r_clk_cnt;
  logic [2:0]    r_bit_idx;
  logic [7:0]    r_shift;
  logic          r_line;
  logic          r_busy;
  logic          r_done;

  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;

  logic w_full;
  logic w_empty;
  logic w_push;
  logic w_pop;
  logic w_done;
  logic w_line;
  logic w_bit_end;

  // Extra pointer MSB distinguishes full from empty when the index bits match.
  assign w_empty   = (r_wr_ptr == r_rd_ptr);
  assign w_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_push    = i_data_valid && !w_full && !i_rst;
  assign w_bit_end = (r_clk_cnt == LAST_CNT);

  assign o_data_ready   = !w_full;
  assign o_tx_data_line = r_line;
  assign o_tx_busy      = r_busy;
  assign o_tx_done      = r_done;

  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr[AW-1:0]] <= i_data_byte;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_pop        = 1'b0;
    w_done       = 1'b0;
    w_line       = 1'b1;
    case (r_state)
      S_IDLE: begin
        if (!w_empty) begin
          w_pop        = 1'b1;
          w_state_next = S_START;
        end
      end
      S_START: begin
        w_line = 1'b0;
        if (w_bit_end) begin
          w_state_next = S_DATA;
        end
      end
      S_DATA: begin
        w_line = r_shift[r_bit_idx];
        if (w_bit_end && (r_bit_idx == 3'd7)) begin
`ifdef UART_TX_PARITY_EN
          w_state_next = S_PARITY;
`else
          w_state_next = S_STOP;
`endif
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        w_line = ^r_shift;
        if (w_bit_end) begin
          w_state_next = S_STOP;
        end
      end
`endif
      S_STOP: begin
        if (w_bit_end) begin
          w_done = 1'b1;
          // Chain straight into the next start bit when more data is queued.
          if (!w_empty) begin
            w_pop        = 1'b1;
            w_state_next = S_START;
          end else begin
            w_state_next = S_IDLE;
          end
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_clk_cnt <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
      r_line    <= 1'b1;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PW'(1);
      end
      if (w_pop) begin
        r_rd_ptr  <= r_rd_ptr + PW'(1);
        r_shift   <= r_mem[r_rd_ptr[AW-1:0]];
        r_bit_idx <= '0;
      end else if ((r_state == S_DATA) && w_bit_end) begin
        r_bit_idx <= r_bit_idx + 3'd1;
      end
      if ((r_state == S_IDLE) || w_bit_end) begin
        r_clk_cnt <= '0;
      end else begin
        r_clk_cnt <= r_clk_cnt + CW'(1);
      end
      r_line <= w_line;
      r_busy <= (w_state_next != S_IDLE);
      r_done <= w_done;
    end
  end

endmodule
